// File: rtl/risc_ctrl_fsm_if.sv
// Control bundle between the IR decode fields and the datapath/memory enables.
// master = controller side, slave = datapath/memory side.
interface risc_ctrl_fsm_if;
   logic [2:0] opcode;
   logic [1:0] op;
   logic [1:0] reg_sel;
   logic [1:0] wb_sel;
   logic       w_en;
   logic       en_A;
   logic       en_B;
   logic       en_C;
   logic       en_status;
   logic       sel_A;
   logic       sel_B;
   logic       load_ir;
   logic       load_pc;
   logic       clear_pc;
   logic       load_addr;
   logic       addr_sel;
   logic       mem_rd;
   logic       mem_wr;
   logic       halted;
   logic       illegal;

   modport master (
      input  opcode, op,
      output reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
             load_ir, load_pc, clear_pc, load_addr, addr_sel, mem_rd, mem_wr,
             halted, illegal
   );

   modport slave (
      output opcode, op,
      input  reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
             load_ir, load_pc, clear_pc, load_addr, addr_sel, mem_rd, mem_wr,
             halted, illegal
   );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle Moore control FSM for the simple RISC CPU (fetch/decode/execute, LDR/STR, HALT).
// Optional macro CTRL_ILLEGAL_TRAP_EN: undefined encodings halt and set the sticky illegal flag.
module risc_ctrl_fsm #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input logic             clk,
   input logic             rst,
   risc_ctrl_fsm_if.master bus
);

   typedef enum logic [4:0] {
      S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM, S_LOAD_A,
      S_LOAD_B, S_ALU, S_WRITE_C, S_STATUS, S_ADDR, S_LOAD_ADDR, S_MEM_RD,
      S_WRITE_MEM, S_LOAD_RD, S_STR_C, S_MEM_WR, S_HALT
   } state_e;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);

   localparam logic [4:0] I_MOVI = 5'b110_10;
   localparam logic [4:0] I_MOVR = 5'b110_00;
   localparam logic [4:0] I_MVN  = 5'b101_11;
   localparam logic [4:0] I_ADD  = 5'b101_00;
   localparam logic [4:0] I_AND  = 5'b101_10;
   localparam logic [4:0] I_CMP  = 5'b101_01;
   localparam logic [4:0] I_LDR  = 5'b011_00;
   localparam logic [4:0] I_STR  = 5'b100_00;

   state_e     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic [4:0] instr;

   logic [1:0] reg_sel, wb_sel;
   logic       w_en, en_a, en_b, en_c, en_status, sel_a, sel_b;
   logic       load_ir, load_pc, clear_pc, load_addr, addr_sel, mem_rd, mem_wr, halted;

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   assign instr = {bus.opcode, bus.op};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RESET;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end
`endif

   // Wait counter is zero outside the memory-read states, so it is cleared on every entry.
   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      reg_sel   = 2'b00;
      wb_sel    = 2'b00;
      w_en      = 1'b0;
      en_a      = 1'b0;
      en_b      = 1'b0;
      en_c      = 1'b0;
      en_status = 1'b0;
      sel_a     = 1'b0;
      sel_b     = 1'b0;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      clear_pc  = 1'b0;
      load_addr = 1'b0;
      addr_sel  = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      halted    = 1'b0;
      case (state_q)
         S_RESET: begin
            load_pc  = 1'b1;
            clear_pc = 1'b1;
            state_d  = S_IF1;
         end
         S_IF1: begin
            mem_rd   = 1'b1;
            addr_sel = 1'b1;
            if (wait_q == WAIT_LAST) state_d = S_IF2;
            else                     wait_d  = wait_q + 4'd1;
         end
         S_IF2: begin
            mem_rd   = 1'b1;
            addr_sel = 1'b1;
            load_ir  = 1'b1;
            state_d  = S_UPDATE_PC;
         end
         S_UPDATE_PC: begin
            load_pc = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (bus.opcode == 3'b111) begin
               state_d = S_HALT;
            end else begin
               case (instr)
                  I_MOVI:                             state_d = S_WRITE_IMM;
                  I_MOVR, I_MVN:                      state_d = S_LOAD_B;
                  I_ADD, I_AND, I_CMP, I_LDR, I_STR:  state_d = S_LOAD_A;
                  default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                     state_d   = S_HALT;
                     illegal_d = 1'b1;
`else
                     state_d   = S_IF1;
`endif
                  end
               endcase
            end
         end
         S_WRITE_IMM: begin
            reg_sel = 2'b10;
            wb_sel  = 2'b10;
            w_en    = 1'b1;
            state_d = S_IF1;
         end
         S_LOAD_A: begin
            reg_sel = 2'b10;
            en_a    = 1'b1;
            state_d = (instr == I_LDR || instr == I_STR) ? S_ADDR : S_LOAD_B;
         end
         S_LOAD_B: begin
            en_b    = 1'b1;
            state_d = (instr == I_CMP) ? S_STATUS : S_ALU;
         end
         S_ALU: begin
            en_c    = 1'b1;
            sel_a   = (instr == I_MOVR || instr == I_MVN);
            state_d = S_WRITE_C;
         end
         S_WRITE_C: begin
            reg_sel = 2'b01;
            w_en    = 1'b1;
            state_d = S_IF1;
         end
         S_STATUS: begin
            en_status = 1'b1;
            state_d   = S_IF1;
         end
         S_ADDR: begin
            sel_b   = 1'b1;
            en_c    = 1'b1;
            state_d = S_LOAD_ADDR;
         end
         S_LOAD_ADDR: begin
            load_addr = 1'b1;
            state_d   = (instr == I_LDR) ? S_MEM_RD : S_LOAD_RD;
         end
         S_MEM_RD: begin
            mem_rd = 1'b1;
            if (wait_q == WAIT_LAST) state_d = S_WRITE_MEM;
            else                     wait_d  = wait_q + 4'd1;
         end
         S_WRITE_MEM: begin
            mem_rd  = 1'b1;
            reg_sel = 2'b01;
            wb_sel  = 2'b11;
            w_en    = 1'b1;
            state_d = S_IF1;
         end
         S_LOAD_RD: begin
            reg_sel = 2'b01;
            en_b    = 1'b1;
            state_d = S_STR_C;
         end
         S_STR_C: begin
            sel_a   = 1'b1;
            en_c    = 1'b1;
            state_d = S_MEM_WR;
         end
         S_MEM_WR: begin
            mem_wr  = 1'b1;
            state_d = S_IF1;
         end
         S_HALT: begin
            halted  = 1'b1;
         end
         default: state_d = S_RESET;
      endcase
   end

   assign bus.reg_sel   = reg_sel;
   assign bus.wb_sel    = wb_sel;
   assign bus.w_en      = w_en;
   assign bus.en_A      = en_a;
   assign bus.en_B      = en_b;
   assign bus.en_C      = en_c;
   assign bus.en_status = en_status;
   assign bus.sel_A     = sel_a;
   assign bus.sel_B     = sel_b;
   assign bus.load_ir   = load_ir;
   assign bus.load_pc   = load_pc;
   assign bus.clear_pc  = clear_pc;
   assign bus.load_addr = load_addr;
   assign bus.addr_sel  = addr_sel;
   assign bus.mem_rd    = mem_rd;
   assign bus.mem_wr    = mem_wr;
   assign bus.halted    = halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign bus.illegal   = illegal_q;
`else
   assign bus.illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed bench for risc_ctrl_fsm: three instances (MEM_LATENCY 1, 2, 3) share clk/rst/IR fields;
// per-cycle expected output words come from a table of hand-written state traces.
module tb_risc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic [1:0] op;

   always #5 clk = ~clk;

   risc_ctrl_fsm_if b0 ();
   risc_ctrl_fsm_if b1 ();
   risc_ctrl_fsm_if b2 ();

   assign b0.opcode = opcode;
   assign b0.op     = op;
   assign b1.opcode = opcode;
   assign b1.op     = op;
   assign b2.opcode = opcode;
   assign b2.op     = op;

   risc_ctrl_fsm #(.MEM_LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(b0));
   risc_ctrl_fsm #(.MEM_LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(b1));
   risc_ctrl_fsm #(.MEM_LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(b2));

   // Output word: {reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
   //               load_ir, load_pc, clear_pc, load_addr, addr_sel, mem_rd, mem_wr, halted, illegal}
   logic [19:0] o0, o1, o2;
   assign o0 = {b0.reg_sel, b0.wb_sel, b0.w_en, b0.en_A, b0.en_B, b0.en_C, b0.en_status,
                b0.sel_A, b0.sel_B, b0.load_ir, b0.load_pc, b0.clear_pc, b0.load_addr,
                b0.addr_sel, b0.mem_rd, b0.mem_wr, b0.halted, b0.illegal};
   assign o1 = {b1.reg_sel, b1.wb_sel, b1.w_en, b1.en_A, b1.en_B, b1.en_C, b1.en_status,
                b1.sel_A, b1.sel_B, b1.load_ir, b1.load_pc, b1.clear_pc, b1.load_addr,
                b1.addr_sel, b1.mem_rd, b1.mem_wr, b1.halted, b1.illegal};
   assign o2 = {b2.reg_sel, b2.wb_sel, b2.w_en, b2.en_A, b2.en_B, b2.en_C, b2.en_status,
                b2.sel_A, b2.sel_B, b2.load_ir, b2.load_pc, b2.clear_pc, b2.load_addr,
                b2.addr_sel, b2.mem_rd, b2.mem_wr, b2.halted, b2.illegal};

   localparam logic [15:0] F_WEN  = 16'h8000;
   localparam logic [15:0] F_ENA  = 16'h4000;
   localparam logic [15:0] F_ENB  = 16'h2000;
   localparam logic [15:0] F_ENC  = 16'h1000;
   localparam logic [15:0] F_ENS  = 16'h0800;
   localparam logic [15:0] F_SELA = 16'h0400;
   localparam logic [15:0] F_SELB = 16'h0200;
   localparam logic [15:0] F_LIR  = 16'h0100;
   localparam logic [15:0] F_LPC  = 16'h0080;
   localparam logic [15:0] F_CPC  = 16'h0040;
   localparam logic [15:0] F_LADR = 16'h0020;
   localparam logic [15:0] F_ASEL = 16'h0010;
   localparam logic [15:0] F_MRD  = 16'h0008;
   localparam logic [15:0] F_MWR  = 16'h0004;
   localparam logic [15:0] F_HLT  = 16'h0002;
   localparam logic [15:0] F_ILL  = 16'h0001;

   localparam logic [19:0] O_RESET = {4'b0000, F_LPC | F_CPC};
   localparam logic [19:0] O_IF1   = {4'b0000, F_MRD | F_ASEL};
   localparam logic [19:0] O_IF2   = {4'b0000, F_MRD | F_ASEL | F_LIR};
   localparam logic [19:0] O_UPC   = {4'b0000, F_LPC};
   localparam logic [19:0] O_DEC   = {4'b0000, 16'h0000};
   localparam logic [19:0] O_WIMM  = {2'b10, 2'b10, F_WEN};
   localparam logic [19:0] O_LA    = {2'b10, 2'b00, F_ENA};
   localparam logic [19:0] O_LB    = {2'b00, 2'b00, F_ENB};
   localparam logic [19:0] O_ALU   = {4'b0000, F_ENC};
   localparam logic [19:0] O_ALUZ  = {4'b0000, F_ENC | F_SELA};
   localparam logic [19:0] O_WC    = {2'b01, 2'b00, F_WEN};
   localparam logic [19:0] O_ST    = {4'b0000, F_ENS};
   localparam logic [19:0] O_ADDR  = {4'b0000, F_SELB | F_ENC};
   localparam logic [19:0] O_LADR  = {4'b0000, F_LADR};
   localparam logic [19:0] O_MRD   = {4'b0000, F_MRD};
   localparam logic [19:0] O_WMEM  = {2'b01, 2'b11, F_MRD | F_WEN};
   localparam logic [19:0] O_LRD   = {2'b01, 2'b00, F_ENB};
   localparam logic [19:0] O_STRC  = {4'b0000, F_SELA | F_ENC};
   localparam logic [19:0] O_MWR   = {4'b0000, F_MWR};
   localparam logic [19:0] O_HALT  = {4'b0000, F_HLT};
   localparam logic [19:0] O_TRAP  = {4'b0000, F_HLT | F_ILL};

   localparam logic [4:0] MOVI  = 5'b110_10;
   localparam logic [4:0] MOVR  = 5'b110_00;
   localparam logic [4:0] MVN   = 5'b101_11;
   localparam logic [4:0] ADD   = 5'b101_00;
   localparam logic [4:0] ANDI  = 5'b101_10;
   localparam logic [4:0] CMP   = 5'b101_01;
   localparam logic [4:0] LDR   = 5'b011_00;
   localparam logic [4:0] STR   = 5'b100_00;
   localparam logic [4:0] HLT   = 5'b111_01;
   localparam logic [4:0] UNDEF = 5'b000_00;

   typedef struct {
      string       tag;
      int          dut;
      logic [4:0]  instr;
      logic        r;
      logic [19:0] exp;
   } vec_t;

   vec_t tv[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input string t, input int d, input logic [4:0] i, input logic r,
                      input logic [19:0] e);
      vec_t v;
      v.tag = t; v.dut = d; v.instr = i; v.r = r; v.exp = e;
      tv.push_back(v);
   endtask

   task automatic add_reset(input string t, input int d);
      add(t, d, UNDEF, 1'b1, O_RESET);
      add(t, d, UNDEF, 1'b1, O_RESET);
   endtask

   task automatic add_fetch(input string t, input int d, input int lat, input logic [4:0] i);
      for (int k = 0; k < lat; k++) add(t, d, i, 1'b0, O_IF1);
      add(t, d, i, 1'b0, O_IF2);
      add(t, d, i, 1'b0, O_UPC);
      add(t, d, i, 1'b0, O_DEC);
   endtask

   function automatic logic [19:0] pick(input int d);
      case (d)
         0:       return o0;
         1:       return o1;
         default: return o2;
      endcase
   endfunction

   task automatic check(input string t, input int step, input logic [19:0] got,
                        input logic [19:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", t, step, got, exp);
      end
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 3'b000;
      op     = 2'b00;

      // MOV imm, L=3: 3xIF1, IF2, UPDATE_PC, DECODE, WRITE_IMM, then IF1 (7 cycles)
      add_reset("movi", 2);
      add_fetch("movi", 2, 3, MOVI);
      add("movi", 2, MOVI, 1'b0, O_WIMM);
      add("movi", 2, MOVI, 1'b0, O_IF1);

      // ADD, CMP, MOV reg, MVN, AND back to back at L=1
      add_reset("add", 0);
      add_fetch("add", 0, 1, ADD);
      add("add", 0, ADD, 1'b0, O_LA);
      add("add", 0, ADD, 1'b0, O_LB);
      add("add", 0, ADD, 1'b0, O_ALU);
      add("add", 0, ADD, 1'b0, O_WC);
      add_fetch("cmp", 0, 1, CMP);
      add("cmp", 0, CMP, 1'b0, O_LA);
      add("cmp", 0, CMP, 1'b0, O_LB);
      add("cmp", 0, CMP, 1'b0, O_ST);
      add_fetch("movr", 0, 1, MOVR);
      add("movr", 0, MOVR, 1'b0, O_LB);
      add("movr", 0, MOVR, 1'b0, O_ALUZ);
      add("movr", 0, MOVR, 1'b0, O_WC);
      add_fetch("mvn", 0, 1, MVN);
      add("mvn", 0, MVN, 1'b0, O_LB);
      add("mvn", 0, MVN, 1'b0, O_ALUZ);
      add("mvn", 0, MVN, 1'b0, O_WC);
      add_fetch("and", 0, 1, ANDI);
      add("and", 0, ANDI, 1'b0, O_LA);
      add("and", 0, ANDI, 1'b0, O_LB);
      add("and", 0, ANDI, 1'b0, O_ALU);
      add("and", 0, ANDI, 1'b0, O_WC);
      add("and", 0, UNDEF, 1'b0, O_IF1);

      // LDR, L=2: 11 cycles with two data-read cycles
      add_reset("ldr", 1);
      add_fetch("ldr", 1, 2, LDR);
      add("ldr", 1, LDR, 1'b0, O_LA);
      add("ldr", 1, LDR, 1'b0, O_ADDR);
      add("ldr", 1, LDR, 1'b0, O_LADR);
      add("ldr", 1, LDR, 1'b0, O_MRD);
      add("ldr", 1, LDR, 1'b0, O_MRD);
      add("ldr", 1, LDR, 1'b0, O_WMEM);
      add("ldr", 1, LDR, 1'b0, O_IF1);

      // STR, L=1: 10 cycles, single mem_wr
      add_reset("str", 0);
      add_fetch("str", 0, 1, STR);
      add("str", 0, STR, 1'b0, O_LA);
      add("str", 0, STR, 1'b0, O_ADDR);
      add("str", 0, STR, 1'b0, O_LADR);
      add("str", 0, STR, 1'b0, O_LRD);
      add("str", 0, STR, 1'b0, O_STRC);
      add("str", 0, STR, 1'b0, O_MWR);
      add("str", 0, STR, 1'b0, O_IF1);

      // Undefined encoding 000_00
      add_reset("undef", 0);
      add_fetch("undef", 0, 1, UNDEF);
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int k = 0; k < 4; k++) add("undef", 0, UNDEF, 1'b0, O_TRAP);
`else
      add("undef", 0, UNDEF, 1'b0, O_IF1);
      add("undef", 0, UNDEF, 1'b0, O_IF2);
`endif

      // HALT: absorbing, no memory reads, illegal cleared by the preceding reset
      add_reset("halt", 0);
      add_fetch("halt", 0, 1, HLT);
      for (int k = 0; k < 22; k++) add("halt", 0, HLT, 1'b0, O_HALT);

      // Reset during IF1 at L=3 must restart the wait count from zero
      add_reset("rstif", 2);
      add("rstif", 2, MOVI, 1'b0, O_IF1);
      add("rstif", 2, MOVI, 1'b0, O_IF1);
      add("rstif", 2, MOVI, 1'b1, O_RESET);
      add_fetch("rstif", 2, 3, MOVI);
      add("rstif", 2, MOVI, 1'b0, O_WIMM);

      for (int k = 0; k < tv.size(); k++) begin
         @(negedge clk);
         rst          = tv[k].r;
         {opcode, op} = tv[k].instr;
         @(posedge clk);
         #1;
         check(tv[k].tag, k, pick(tv[k].dut), tv[k].exp);
      end

      // Asynchronous reset in the middle of an ADD (L=1)
      @(negedge clk);
      rst          = 1'b1;
      {opcode, op} = ADD;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("async_pre", 0, o0, O_LB);
      rst = 1'b1;
      #1;
      check("async_now", 0, o0, O_RESET);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("async_hold", k, o0, O_RESET);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("async_rel", 0, o0, O_RESET);
      @(posedge clk);
      #1;
      check("async_if1", 0, o0, O_IF1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/risc_ctrl_fsm.md
# risc_ctrl_fsm

Multi-cycle control FSM for the simple RISC CPU. It fetches, decodes and executes one instruction at a time, and drives the register-file, datapath, PC/IR and memory-interface enables. It adds fetch, PC update, LDR/STR, HALT and a parametrised memory wait-state count to the single-instruction controller generation. It sits between the instruction register decode fields and the datapath/memory control pins.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles a memory read must be held before data is valid. Legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  3  IR[15:13].
- op  in  2  IR[12:11].
- reg_sel  out  2  register select: 10 = Rn, 01 = Rd, 00 = Rm.
- wb_sel  out  2  write-back source: 00 = C, 10 = sx(imm8), 11 = mem data.
- w_en  out  1  register-file write.
- en_A, en_B, en_C, en_status  out  1 each  datapath register loads.
- sel_A, sel_B  out  1 each  sel_A=1 forces A operand to 0; sel_B=1 selects sx(imm5).
- load_ir  out  1  IR load.
- load_pc  out  1  PC load.
- clear_pc  out  1  PC next = 0 (with load_pc); else PC+1.
- load_addr  out  1  data-address register load from C.
- addr_sel  out  1  1 = memory address from PC, 0 = from data-address register.
- mem_rd, mem_wr  out  1 each  memory command.
- halted  out  1  CPU stopped.
- illegal  out  1  sticky undefined-instruction flag (only with the trap macro; tied 0 otherwise).

## Operation
- Moore FSM; every output decodes the current state only. Any output not listed for a state is 0.
- RESET: load_pc=1, clear_pc=1. Next state is always IF1.
- IF1: mem_rd=1, addr_sel=1. Stays for exactly MEM_LATENCY cycles, counted by an internal wait counter that clears on entry, then goes to IF2.
- IF2: mem_rd=1, addr_sel=1, load_ir=1. Next state UPDATE_PC.
- UPDATE_PC: load_pc=1. Next state DECODE.
- DECODE dispatch on {opcode, op}:
  - 110_10 MOV imm: WRITE_IMM.
  - 110_00 MOV reg and 101_11 MVN: LOAD_B.
  - 101_00 ADD, 101_10 AND, 101_01 CMP, 011_00 LDR, 100_00 STR: LOAD_A.
  - 111_xx: HALT.
  - Anything else: see Configuration.
- WRITE_IMM: reg_sel=10, wb_sel=10, w_en=1. Next state IF1.
- LOAD_A: reg_sel=10, en_A=1.
  - ADD/AND/CMP go to LOAD_B.
  - LDR/STR go to ADDR.
- LOAD_B: reg_sel=00, en_B=1. CMP goes to STATUS; all others go to ALU.
- ALU: en_C=1; sel_A=1 for MOV reg and MVN. Next state WRITE_C.
- WRITE_C: reg_sel=01, wb_sel=00, w_en=1. Next state IF1.
- STATUS: en_status=1. Next state IF1.
- ADDR: sel_B=1, en_C=1. Next state LOAD_ADDR.
- LOAD_ADDR: load_addr=1. LDR goes to MEM_RD; STR goes to LOAD_RD.
- MEM_RD: mem_rd=1, addr_sel=0, for MEM_LATENCY cycles. Next state WRITE_MEM.
- WRITE_MEM: mem_rd=1, addr_sel=0, reg_sel=01, wb_sel=11, w_en=1. Next state IF1.
- LOAD_RD: reg_sel=01, en_B=1. Next state STR_C.
- STR_C: sel_A=1, en_C=1. Next state MEM_WR.
- MEM_WR: mem_wr=1, addr_sel=0, for one cycle. Next state IF1.
- HALT: halted=1. Absorbing; only rst exits.
- opcode/op are sampled in every state after DECODE, so the IR must stay stable until the next IF2.

## Timing
- Cycles per instruction, counted from IF1 entry to the next IF1 entry, with L = MEM_LATENCY:
  - MOV imm: L+4
  - MOV reg/MVN: L+6
  - ADD/AND: L+7
  - CMP: L+6
  - LDR: 2L+7
  - STR: L+9
- After rst deasserts: one RESET cycle, then IF1.
- rst asserted at any time forces RESET immediately (asynchronously). While rst is held, outputs are load_pc=1, clear_pc=1, all others 0. The wait counter and illegal are cleared.
- The wait counter never wraps: MEM_LATENCY=15 gives exactly 15 IF1 cycles.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an undefined {opcode, op} in DECODE goes to HALT and sets illegal=1. illegal stays set until rst.
- CTRL_ILLEGAL_TRAP_EN undefined: an undefined encoding returns from DECODE to IF1 as a NOP (fetch L+3 cycles). illegal is constant 0.

## Test plan
- Reset: rst=1 for 3 cycles mid-ADD → immediately load_pc=clear_pc=1, all else 0. After release: 1 RESET cycle, then IF1 with mem_rd=1, addr_sel=1.
- MEM_LATENCY=3, MOV R0,#7 (110_10) → IF1 for 3 cycles, then IF2 load_ir, UPDATE_PC load_pc. WRITE_IMM has reg_sel=10, wb_sel=10, w_en=1. Total 7 cycles back to IF1.
- ADD then CMP (L=1) → en_A with reg_sel=10, then en_B with reg_sel=00, en_C, then w_en with reg_sel=01, wb_sel=00 (ADD, 8 cycles). CMP asserts en_status, never w_en (7 cycles).
- LDR with L=2 → ADDR has sel_B=1, en_C=1; load_addr; mem_rd with addr_sel=0 for 2 cycles; WRITE_MEM wb_sel=11, w_en=1. Total 11 cycles.
- STR with L=1 → LOAD_RD en_B, reg_sel=01; STR_C sel_A=1, en_C=1; exactly one mem_wr cycle with addr_sel=0. Total 10 cycles; w_en never 1.
- Opcode 111 → halted=1 held for 20+ cycles, no mem_rd. Opcode 000_00 → with the trap macro: HALT with illegal=1. Without it: next IF1 after L+3 cycles, illegal=0.
